// File: rtl/me_pkg.sv
// Shared types and sizing helpers for the motion-estimation pixel feeder.
package me_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    CUR,
    SRCH,
    DRAIN
  } feeder_state_t;

  // Tag index fields are sized for windows up to 256 pixels wide.
  localparam int unsigned TAG_IDX_W = 8;

  typedef struct packed {
    logic                 sel;
    logic [TAG_IDX_W-1:0] band;
    logic [TAG_IDX_W-1:0] col;
    logic                 last;
  } beat_tag_t;

  function automatic int unsigned num_bands(input int unsigned macro_dim,
                                            input int unsigned search_dim);
    return search_dim - macro_dim;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/me_feed_addr_gen.sv
// Column/band read-address counters for the pixel feeder; the column runs fastest
// and wraps at the macroblock edge (current MB) or the search edge (search window).
module me_feed_addr_gen
  import me_pkg::*;
#(
  parameter  int unsigned MACRO_DIM  = 16,
  parameter  int unsigned SEARCH_DIM = 48,
  localparam int unsigned NUM_BANDS  = num_bands(MACRO_DIM, SEARCH_DIM),
  localparam int unsigned COL_W      = idx_w(SEARCH_DIM),
  localparam int unsigned BAND_W     = idx_w(NUM_BANDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic              srch_mode,
  output logic [COL_W-1:0]  col,
  output logic [BAND_W-1:0] band,
  output logic              last_c
);

  logic col_last_c;
  logic band_last_c;

  assign col_last_c  = srch_mode ? (col == COL_W'(SEARCH_DIM - 1))
                                 : (col == COL_W'(MACRO_DIM - 1));
  assign band_last_c = (band == BAND_W'(NUM_BANDS - 1));
  assign last_c      = col_last_c && (!srch_mode || band_last_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      band <= '0;
    end else if (clear) begin
      col  <= '0;
      band <= '0;
    end else if (advance) begin
      if (col_last_c) begin
        col <= '0;
        if (srch_mode) begin
          band <= band_last_c ? '0 : band + BAND_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/me_pixel_feeder.sv
// Streams the current macroblock, then the search window band by band, into the
// ME core through a two-stage (memory, output) pipeline with valid/ready back-pressure.
module me_pixel_feeder
  import me_pkg::*;
#(
  parameter  int unsigned MACRO_DIM  = 16,
  parameter  int unsigned SEARCH_DIM = 48,
  localparam int unsigned NUM_BANDS  = num_bands(MACRO_DIM, SEARCH_DIM),
  localparam int unsigned CUR_W      = idx_w(MACRO_DIM),
  localparam int unsigned COL_W      = idx_w(SEARCH_DIM),
  localparam int unsigned BAND_W     = idx_w(NUM_BANDS),
  localparam int unsigned CUR_DW     = MACRO_DIM * 8,
  localparam int unsigned DATA_W     = (MACRO_DIM + 1) * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cur_rd_en,
  output logic [CUR_W-1:0]  cur_rd_addr,
  input  logic [CUR_DW-1:0] cur_rd_data,
  output logic              srch_rd_en,
  output logic [COL_W-1:0]  srch_rd_col,
  output logic [COL_W-1:0]  srch_rd_row,
  input  logic [DATA_W-1:0] srch_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic [BAND_W-1:0] out_band,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last
);

  feeder_state_t     state;
  logic [COL_W-1:0]  col;
  logic [BAND_W-1:0] band;
  logic              last_issue_c;
  logic              stall_c;
  logic              issue_c;
  logic              accept_c;
  logic              xfer_c;
  logic              s1_valid;
  beat_tag_t         s1_tag;

  assign stall_c  = out_valid && !out_ready;
  assign issue_c  = !stall_c && ((state == CUR) || (state == SRCH));
  assign accept_c = (state == IDLE) && start;
  assign xfer_c   = out_valid && out_ready;

  // Read strobes must follow out_ready in the same cycle so a stall freezes the memories.
  assign cur_rd_en   = issue_c && (state == CUR);
  assign srch_rd_en  = issue_c && (state == SRCH);
  assign cur_rd_addr = CUR_W'(col);
  assign srch_rd_col = col;
  assign srch_rd_row = COL_W'(band);

  me_feed_addr_gen #(
    .MACRO_DIM  (MACRO_DIM),
    .SEARCH_DIM (SEARCH_DIM)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_c),
    .advance   (issue_c),
    .srch_mode (state == SRCH),
    .col       (col),
    .band      (band),
    .last_c    (last_issue_c)
  );

  // Pass sequencing: busy/done and the read-phase state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CUR;
            busy  <= 1'b1;
          end
        end
        CUR: begin
          if (issue_c && last_issue_c) begin
            state <= SRCH;
          end
        end
        SRCH: begin
          if (issue_c && last_issue_c) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer_c && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // s1 tracks what the memories present this cycle; s2 is the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      out_data  <= '0;
      out_band  <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (!stall_c) begin
      s1_valid <= issue_c;
      if (issue_c) begin
        s1_tag.sel  <= (state == SRCH);
        s1_tag.band <= (state == SRCH) ? TAG_IDX_W'(band) : '0;
        s1_tag.col  <= TAG_IDX_W'(col);
        s1_tag.last <= (state == SRCH) && last_issue_c;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sel  <= s1_tag.sel;
        out_band <= BAND_W'(s1_tag.band);
        out_col  <= COL_W'(s1_tag.col);
        out_last <= s1_tag.last;
        out_data <= s1_tag.sel ? srch_rd_data : {pixel_t'(0), cur_rd_data};
      end else begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Randomized bench for me_pixel_feeder: default and small configurations checked
// beat-by-beat against an index-arithmetic model of the pass order.
module tb_me_pixel_feeder;

  localparam int MD   = 16;
  localparam int SD   = 48;
  localparam int NB   = SD - MD;
  localparam int TOT  = MD + NB * SD;
  localparam int DW   = (MD + 1) * 8;
  localparam int SMD  = 4;
  localparam int SSD  = 8;
  localparam int STOT = SMD + (SSD - SMD) * SSD;
  localparam int SDW  = (SMD + 1) * 8;

  logic clk, rst;

  logic          start, busy, done, cur_rd_en, srch_rd_en;
  logic [3:0]    cur_rd_addr;
  logic [MD*8-1:0] cur_rd_data;
  logic [5:0]    srch_rd_col, srch_rd_row;
  logic [DW-1:0] srch_rd_data;
  logic          out_valid, out_ready, out_sel, out_last;
  logic [DW-1:0] out_data;
  logic [4:0]    out_band;
  logic [5:0]    out_col;

  logic           s_start, s_busy, s_done, s_cur_rd_en, s_srch_rd_en;
  logic [1:0]     s_cur_rd_addr;
  logic [SMD*8-1:0] s_cur_rd_data;
  logic [2:0]     s_srch_rd_col, s_srch_rd_row;
  logic [SDW-1:0] s_srch_rd_data;
  logic           s_out_valid, s_out_ready, s_out_sel, s_out_last;
  logic [SDW-1:0] s_out_data;
  logic [1:0]     s_out_band;
  logic [2:0]     s_out_col;

  int n_chk  = 0;
  int n_pass = 0;
  int bi     = 0;
  int sbi    = 0;
  logic [7:0] key  = 8'h00;
  logic [7:0] skey = 8'h00;

  me_pixel_feeder #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data),
    .srch_rd_en(srch_rd_en), .srch_rd_col(srch_rd_col), .srch_rd_row(srch_rd_row),
    .srch_rd_data(srch_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_data(out_data), .out_band(out_band), .out_col(out_col),
    .out_last(out_last)
  );

  me_pixel_feeder #(.MACRO_DIM(SMD), .SEARCH_DIM(SSD)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .cur_rd_en(s_cur_rd_en), .cur_rd_addr(s_cur_rd_addr), .cur_rd_data(s_cur_rd_data),
    .srch_rd_en(s_srch_rd_en), .srch_rd_col(s_srch_rd_col), .srch_rd_row(s_srch_rd_row),
    .srch_rd_data(s_srch_rd_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sel(s_out_sel), .out_data(s_out_data), .out_band(s_out_band), .out_col(s_out_col),
    .out_last(s_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int sd, input int r, input int c, input logic [7:0] k);
    return 8'((r * sd + c) % 256) ^ k;
  endfunction

  // Expected i-th beat of a pass, packed as {last, sel, band, col, data}.
  function automatic logic [255:0] exp_beat(input int md, input int sd, input logic [7:0] k,
                                            input int i);
    logic [255:0] v;
    int b, c;
    logic sel;
    v = '0;
    if (i < md) begin
      sel = 1'b0; b = 0; c = i;
      for (int j = 0; j < md; j++) v[8*j +: 8] = pix(sd, j, c, k);
    end else begin
      sel = 1'b1; b = (i - md) / sd; c = (i - md) % sd;
      for (int j = 0; j <= md; j++) v[8*j +: 8] = pix(sd, b + j, c, k);
    end
    v[255]     = (i == md + (sd - md) * sd - 1);
    v[254]     = sel;
    v[253:246] = 8'(b);
    v[245:238] = 8'(c);
    return v;
  endfunction

  function automatic logic [255:0] pack(input logic last, input logic sel, input int b,
                                        input int c, input logic [199:0] d);
    logic [255:0] v;
    v = 256'(d);
    v[255]     = last;
    v[254]     = sel;
    v[253:246] = 8'(b);
    v[245:238] = 8'(c);
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Buffer models: one-cycle read latency, data held while enable is low.
  always @(posedge clk) begin
    if (cur_rd_en)
      for (int j = 0; j < MD; j++) cur_rd_data[8*j +: 8] <= pix(SD, j, int'(cur_rd_addr), key);
    if (srch_rd_en)
      for (int j = 0; j <= MD; j++)
        srch_rd_data[8*j +: 8] <= pix(SD, int'(srch_rd_row) + j, int'(srch_rd_col), key);
    if (s_cur_rd_en)
      for (int j = 0; j < SMD; j++) s_cur_rd_data[8*j +: 8] <= pix(SSD, j, int'(s_cur_rd_addr), skey);
    if (s_srch_rd_en)
      for (int j = 0; j <= SMD; j++)
        s_srch_rd_data[8*j +: 8] <= pix(SSD, int'(s_srch_rd_row) + j, int'(s_srch_rd_col), skey);
  end

  // Default-config monitor: beat order, stall stability, done timing, read exclusivity.
  initial begin : mon_big
    logic prev_stall, last_xfer;
    logic [255:0] prev_out, cur, r;
    prev_stall = 1'b0; last_xfer = 1'b0; prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        last_xfer  = 1'b0;
      end else begin
        cur = pack(out_last, out_sel, int'(out_band), int'(out_col), 200'(out_data));
        if (prev_stall) check("stall_hold", cur, prev_out);
        if (done || last_xfer) check("done_timing", 256'(done), 256'(last_xfer));
        if (cur_rd_en && srch_rd_en) check("rd_excl", 256'(1), 256'(0));
        last_xfer = 1'b0;
        if (out_valid && out_ready) begin
          if (bi < TOT) check("beat", cur, exp_beat(MD, SD, key, bi));
          else check("beat_extra", 256'(bi), 256'(TOT - 1));
          if (bi == MD + 5 * SD + 7 && key == 8'h00) begin
            r = '0;
            for (int j = 0; j <= MD; j++) r[8*j +: 8] = 8'(((5 + j) * 48 + 7) % 256);
            check("b5c7", 256'(out_data), r);
          end
          last_xfer = out_last;
          bi++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = cur;
      end
    end
  end

  // Small-config monitor.
  initial begin : mon_small
    logic last_xfer;
    logic [255:0] cur;
    last_xfer = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_xfer = 1'b0;
      end else begin
        if (s_done || last_xfer) check("s_done_timing", 256'(s_done), 256'(last_xfer));
        last_xfer = 1'b0;
        if (s_out_valid && s_out_ready) begin
          cur = pack(s_out_last, s_out_sel, int'(s_out_band), int'(s_out_col), 200'(s_out_data));
          if (sbi < STOT) check("s_beat", cur, exp_beat(SMD, SSD, skey, sbi));
          else check("s_beat_extra", 256'(sbi), 256'(STOT - 1));
          if (!s_out_sel) check("s_top_byte", 256'(s_out_data[SDW-1 -: 8]), 256'(0));
          last_xfer = s_out_last;
          sbi++;
        end
      end
    end
  end

  task automatic wait_done(input int budget, input int pct_low, input int again_at);
    bit ok, pulsed;
    ok = 1'b0; pulsed = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      out_ready = ($urandom_range(0, 99) >= pct_low);
      if (again_at >= 0 && !pulsed && bi >= again_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) ok = 1'b1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("done_seen", 256'(ok), 256'(1));
  endtask

  function automatic logic [255:0] big_outs();
    return 256'({busy, done, cur_rd_en, cur_rd_addr, srch_rd_en, srch_rd_col, srch_rd_row,
                 out_valid, out_sel, out_band, out_col, out_last, out_data});
  endfunction

  initial begin : main
    bit reached;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; s_start = 1'b0; s_out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Asynchronous reset while idle.
    #2 rst = 1'b1;
    #1 check("rst_idle_outs", big_outs(), 256'(0));
    step();
    rst = 1'b0;
    step();

    // Pass 1: ready always high, latency and full sequence.
    bi = 0; key = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_rise", 256'(busy), 256'(1));
    check("lat_e0", 256'(out_valid), 256'(0));
    step();
    check("lat_e1", 256'(out_valid), 256'(0));
    step();
    check("lat_e2", 256'(out_valid), 256'(1));
    wait_done(3000, 0, -1);
    check("p1_beats", 256'(bi), 256'(TOT));
    check("p1_busy_fall", 256'(busy), 256'(0));

    // Pass 2: started in the done cycle, 30% back-pressure.
    bi = 0; key = 8'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_start", 256'(busy), 256'(1));
    wait_done(8000, 30, -1);
    check("p2_beats", 256'(bi), 256'(TOT));
    check("p2_busy_fall", 256'(busy), 256'(0));
    step();

    // Pass 3: stray start at beat 100 must be ignored.
    bi = 0; key = 8'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(8000, 20, 100);
    check("p3_beats", 256'(bi), 256'(TOT));
    repeat (10) step();
    check("p3_idle_after", 256'({busy, out_valid}), 256'(0));
    check("p3_no_extra", 256'(bi), 256'(TOT));

    // Pass 4: reset during the search phase.
    bi = 0; key = 8'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 4000 && !reached; n++) begin
      out_ready = ($urandom_range(0, 99) >= 30);
      step();
      if (bi >= 500) reached = 1'b1;
    end
    check("abort_reach", 256'(reached), 256'(1));
    #2 rst = 1'b1;
    #1 check("rst_mid_outs", big_outs(), 256'(0));
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    check("abort_idle", 256'({busy, out_valid}), 256'(0));

    // Pass 5: fresh pass after the abort.
    bi = 0; key = 8'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(8000, 30, -1);
    check("p5_beats", 256'(bi), 256'(TOT));

    // Small configuration with back-pressure.
    sbi = 0; skey = 8'($urandom); s_start = 1'b1;
    step();
    s_start = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 500 && !reached; n++) begin
      s_out_ready = ($urandom_range(0, 99) >= 30);
      step();
      if (s_done) reached = 1'b1;
    end
    s_out_ready = 1'b1;
    check("s_done_seen", 256'(reached), 256'(1));
    check("s_beats", 256'(sbi), 256'(STOT));
    check("s_busy_fall", 256'(s_busy), 256'(0));

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/me_pixel_feeder.md
Name: me_pixel_feeder

Overview:
- Drives the motion-estimation engine's pixel inputs from on-chip buffers. This block is the producer for the ME core's current-pixel and search-pixel ports.
- On start it streams:
  - the current macroblock, one column per beat (MACRO_DIM beats);
  - then the search window, column by column, for each vertical band of MACRO_DIM+1 rows.
- It sits between the frame/search buffers and the ME core, replacing hand-driven stimulus with synthesizable sequencing plus valid/ready back-pressure.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search window edge in pixels; must be greater than MACRO_DIM.
- NUM_BANDS, SEARCH_DIM-MACRO_DIM, derived (localparam): vertical band starts 0..NUM_BANDS-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- cur_rd_en  out  1  current-MB buffer read enable.
- cur_rd_addr  out  clog2(MACRO_DIM)  column index.
- cur_rd_data  in  MACRO_DIM*8  column, pixel j (row j) at bits [8j+7:8j]; valid 1 cycle after enable; held while enable is low.
- srch_rd_en  out  1  search buffer read enable.
- srch_rd_col  out  clog2(SEARCH_DIM)  column index.
- srch_rd_row  out  clog2(SEARCH_DIM)  band start row.
- srch_rd_data  in  (MACRO_DIM+1)*8  rows row..row+MACRO_DIM of the column, pixel j at [8j+7:8j]; same latency and hold rules as cur_rd_data.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_sel  out  1  0 = current-MB column, 1 = search column.
- out_data  out  (MACRO_DIM+1)*8  beat payload; for sel=0 the top byte is 0.
- out_band  out  clog2(NUM_BANDS)  band of a search beat; 0 for sel=0.
- out_col  out  clog2(SEARCH_DIM)  column index of the beat.
- out_last  out  1  high on the final beat of the pass.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters cleared. Reset mid-pass abandons the pass with no done pulse.
- FSM states:
  - IDLE: start=1 -> CUR; col=0, band=0.
  - CUR: issues reads col 0..MACRO_DIM-1; after the last issue -> SRCH with col=0.
  - SRCH: issues (col, band) with col incrementing fastest; col wraps at SEARCH_DIM-1 and band increments. After issuing (SEARCH_DIM-1, NUM_BANDS-1) -> DRAIN.
  - DRAIN: waits for the final beat to be accepted, then pulses done -> IDLE.
- Two-stage pipeline:
  - s1 is the memory output stage, with a tracked valid bit and tag (sel/band/col/last).
  - s2 is the output register.
  - stall = out_valid && !out_ready.
- During a stall: both rd_en are low, counters and s1 are frozen, and the memory holds its data. s2 holds all out_* signals stable.
- When not stalled: s2 loads s1 (or clears out_valid if s1 is empty); a new read issues if the state is CUR or SRCH.
- Beat transfer occurs on out_valid && out_ready.
- Latency: with out_ready held high, first out_valid is 2 cycles after the start-sampling edge. There is one beat per cycle, with no bubble at the CUR->SRCH transition.
- Beat count: MACRO_DIM + NUM_BANDS*SEARCH_DIM beats per pass. done occurs 1 cycle after the out_last beat transfers.
- start while busy is ignored.
- start coincident with rst: rst wins.
- A new start in the same cycle as done is accepted.
- Only one of cur_rd_en / srch_rd_en is high in any cycle.

Decomposition:
- Package me_pkg holds:
  - the pixel_t (8-bit) typedef;
  - the feeder_state_t enum {IDLE, CUR, SRCH, DRAIN};
  - the NUM_BANDS computation function;
  - the beat tag struct (sel, band, col, last).
- One sub-module, me_feed_addr_gen: the col/band counters with advance enable and last-issue flag.
- Pipeline and FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle while idle -> all outputs 0 immediately (async), busy=0.
- Full pass, defaults, out_ready=1, buffers filled with pixel = (row*SEARCH_DIM + col) mod 256:
  - start at edge 0 -> out_valid first at edge 2;
  - 1552 beats, the first 16 with sel=0;
  - search beat (band 5, col 7) carries bytes j = (5+j)*48+7 mod 256;
  - out_last on beat 1552; done pulses one cycle later; busy falls with done.
- Back-pressure: out_ready toggled pseudo-randomly, 30% low -> identical beat sequence to the no-stall run; out_* stable across every stalled cycle; no beat duplicated or dropped.
- Small config MACRO_DIM=4, SEARCH_DIM=8: exactly 4 + 4*8 = 36 beats; the band counter wraps after col 7; out_data top byte is 0 on all sel=0 beats.
- start pulsed again at beat 100 while busy -> ignored; beat count still 1552 and exactly one done.
- rst asserted during SRCH at beat 500, then start after release -> no done from the aborted pass; the new pass starts from cur col 0 and completes normally.
